calc_cmd_sequencer: RTL and testbench
=====================================

Name: calc_cmd_sequencer

Overview:
Front-end command stage that sits directly upstream of the small-calculator control unit. It synchronises and debounces the raw GO push-button and turns each press into a one-cycle go pulse. It captures op/in1/in2 from the switches and holds them stable until the control unit reports done. It also flags presses that arrive while busy, flags a hung control unit, and counts completed commands.

Parameters:
W, 4, operand width of in1/in2.
DEB_CYCLES, 100000, consecutive stable cycles required before the debounced button changes state; must be >= 2.
TIMEOUT, 64, maximum BUSY cycles to wait for done; must be >= 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
btn_go  in  1  raw, asynchronous, bouncy GO button.
sw_op  in  2  requested operation: 0 ADD, 1 SUB, 2 AND, 3 XOR.
sw_in1  in  W  operand 1 switches.
sw_in2  in  W  operand 2 switches.
done  in  1  done from the control unit; one-cycle level.
go  out  1  one-cycle start pulse to the control unit.
op  out  2  latched operation.
in1  out  W  latched operand 1.
in2  out  W  latched operand 2.
busy  out  1  high from LAUNCH until completion or timeout.
ack  out  1  one-cycle pulse, registered one cycle after done is accepted.
err_overlap  out  1  sticky: a press occurred while not IDLE.
err_timeout  out  1  sticky: done was not seen within TIMEOUT BUSY cycles.
cmd_count  out  8  number of completed commands; wraps 255->0.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, sync flops 0, debounced state 0, all counters 0.
- Synchroniser: two-flop synchroniser on btn_go gives s.
- Debounce: counter dc increments while s != db and clears to 0 when s == db.
  - At an edge where s != db and dc == DEB_CYCLES-1: db <= s and dc <= 0.
  - press = db & ~db_q, where db_q is db delayed one cycle. Falling edges are ignored.
- Latency: btn_go first sampled high at edge 0 and held stable -> db rises at edge DEB_CYCLES+1 -> go high for exactly the cycle after edge DEB_CYCLES+2.
- FSM, all outputs registered:
  - IDLE: busy=0. On press, at the same edge:
    - latch sw_op/sw_in1/sw_in2 into op/in1/in2;
    - clear err_overlap and err_timeout;
    - go to LAUNCH.
  - LAUNCH (1 cycle): go=1, busy=1, then BUSY. Clear the timeout counter tc.
  - BUSY: go=0, busy=1, tc increments each cycle.
    - If done=1: go to IDLE, ack=1 next cycle, cmd_count+1.
    - Else if tc == TIMEOUT-1: go to IDLE, set err_timeout, no ack, cmd_count unchanged.
- op/in1/in2 change only on an accepted press. Switch changes outside that edge have no effect.
- A press in LAUNCH or BUSY sets err_overlap and is otherwise dropped; it is not queued.
- Simultaneous events:
  - done and timeout in the same cycle: done wins, no error.
  - done and press in the same BUSY cycle: complete normally and set err_overlap.
- done in IDLE or LAUNCH: ignored.
- Button held through reset release: db rises after debounce and counts as a valid press.
- Reset mid-operation: immediate return to IDLE with everything cleared. The control unit shares rst, so no partial command survives.

Decomposition:
- Shared package calc_pkg:
  - OP_ADD=2'd0, OP_SUB=2'd1, OP_AND=2'd2, OP_XOR=2'd3;
  - sequencer state encoding IDLE/LAUNCH/BUSY.
- One sub-module, calc_debounce: synchroniser + stability counter + rising-edge detect. Parameter DEB_CYCLES; ports clk, rst, raw, level, rise.
- The top level holds the FSM, capture registers, timeout counter, error flags and cmd_count.

Test Plan:
All scenarios use DEB_CYCLES=4 and TIMEOUT=16.
1. Basic command: sw_op=1, sw_in1=4'h9, sw_in2=4'h3; btn_go high from edge 0 for 20 cycles; done pulsed 6 cycles after go -> one go pulse after edge 6; op=1, in1=9, in2=3 throughout; busy high 7 cycles; ack one cycle after done; cmd_count=1.
2. Bounce: btn_go toggles every 2 cycles for 12 cycles, then stays 1 -> exactly one go, 7 cycles after bouncing stops; no go during the bounce.
3. Overlap: second clean press while BUSY -> no second go, err_overlap=1; press again after ack -> go issued, err_overlap cleared.
4. Timeout: press and never drive done -> busy falls after 16 BUSY cycles, err_timeout=1, ack stays 0, cmd_count unchanged.
5. Hold: change sw_in1 9->F and sw_op 1->3 during BUSY -> in1=9 and op=1 until the next accepted press; done in IDLE -> no ack, no count change.
6. Reset mid-BUSY with cmd_count=255 before a completion -> all outputs 0 immediately on rst, before the next clk edge. Separately, 256 completions -> cmd_count wraps to 0.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : calc_pkg                                               |
// | Description : Shared constants for the small-calculator front end:   |
// |               operation codes and command-sequencer state encoding.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package calc_pkg;

  // Operation codes understood by the control unit
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  // Sequencer state encoding (plain constants so older blocks can share it)
  typedef logic [1:0] seq_state_t;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/calc_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : calc_debounce                                          |
// | Description : Two-flop synchroniser, stability-count debouncer and   |
// |               rising-edge detector for a raw push-button.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module calc_debounce #(
  parameter int DEB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  // Counter only has to reach DEB_CYCLES-1 before it is cleared again
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic          db_dly_q;
  logic [CW-1:0] dc_q;
  logic [CW-1:0] dc_d;

  // Count consecutive cycles where the synchronised input disagrees with
  // the debounced state; adopt the new value once it has held long enough
  always_comb begin
    dc_d = '0;
    db_d = db_q;
    if (sync2_q != db_q) begin
      if (dc_q == DEB_LAST) begin
        db_d = sync2_q;
      end else begin
        dc_d = dc_q + CW'(1);
      end
    end
  end

  // Synchroniser, debounce state and one-cycle delayed copy for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      dc_q     <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      dc_q     <= dc_d;
    end
  end

  assign level = db_q;
  assign rise  = db_q & ~db_dly_q;

endmodule
`default_nettype wire

// File: rtl/calc_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : calc_cmd_sequencer                                     |
// | Description : Command front end for the calculator control unit:     |
// |               debounced GO press -> operand capture -> go pulse,     |
// |               completion tracking, overlap/timeout flags, counter.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module calc_cmd_sequencer #(
  parameter int W          = 4,
  parameter int DEB_CYCLES = 100000,
  parameter int TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_go,
  input  logic [1:0]   sw_op,
  input  logic [W-1:0] sw_in1,
  input  logic [W-1:0] sw_in2,
  input  logic         done,
  output logic         go,
  output logic [1:0]   op,
  output logic [W-1:0] in1,
  output logic [W-1:0] in2,
  output logic         busy,
  output logic         ack,
  output logic         err_overlap,
  output logic         err_timeout,
  output logic [7:0]   cmd_count
);

  import calc_pkg::*;

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic press;
  logic db_level;

  calc_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_go),
    .level (db_level),
    .rise  (press)
  );

  seq_state_t   state_q, state_d;
  logic [TW-1:0] tc_q, tc_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] in1_q, in1_d;
  logic [W-1:0] in2_q, in2_d;
  logic         go_q, go_d;
  logic         busy_q, busy_d;
  logic         ack_q, ack_d;
  logic         ovl_q, ovl_d;
  logic         tmo_q, tmo_d;
  logic [7:0]   cnt_q, cnt_d;

  // Next-state logic; go/busy are derived from the next state so that the
  // registered outputs line up with the state they describe
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    op_d    = op_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    ack_d   = 1'b0;
    ovl_d   = ovl_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_LAUNCH;
          op_d    = sw_op;
          in1_d   = sw_in1;
          in2_d   = sw_in2;
          ovl_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_BUSY;
        tc_d    = '0;
        if (press) ovl_d = 1'b1;
      end
      ST_BUSY: begin
        tc_d = tc_q + TW'(1);
        if (press) ovl_d = 1'b1;
        // done takes priority over a coincident timeout
        if (done) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end else if (tc_q == TO_LAST) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    go_d   = (state_d == ST_LAUNCH);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers, cleared immediately by the shared reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tc_q    <= '0;
      op_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      ovl_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      op_q    <= op_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      ovl_q   <= ovl_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign go          = go_q;
  assign op          = op_q;
  assign in1         = in1_q;
  assign in2         = in2_q;
  assign busy        = busy_q;
  assign ack         = ack_q;
  assign err_overlap = ovl_q;
  assign err_timeout = tmo_q;
  assign cmd_count   = cnt_q;

  // The debounced level itself is not needed beyond edge detection
  logic unused_level;
  assign unused_level = db_level;

endmodule
`default_nettype wire

// File: tb/tb_calc_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_calc_cmd_sequencer                                  |
// | Description : Directed self-checking bench for calc_cmd_sequencer    |
// |               with DEB_CYCLES=4, TIMEOUT=16.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_calc_cmd_sequencer;
  import calc_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_go = 1'b0;
  logic         done = 1'b0;
  logic [1:0]   sw_op = 2'd0;
  logic [W-1:0] sw_in1 = '0;
  logic [W-1:0] sw_in2 = '0;
  logic         go, busy, ack, err_overlap, err_timeout;
  logic [1:0]   op;
  logic [W-1:0] in1, in2;
  logic [7:0]   cmd_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  int busy_cyc;
  logic go_seen;

  calc_cmd_sequencer #(
    .W          (W),
    .DEB_CYCLES (4),
    .TIMEOUT    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_go      (btn_go),
    .sw_op       (sw_op),
    .sw_in1      (sw_in1),
    .sw_in2      (sw_in2),
    .done        (done),
    .go          (go),
    .op          (op),
    .in1         (in1),
    .in2         (in2),
    .busy        (busy),
    .ack         (ack),
    .err_overlap (err_overlap),
    .err_timeout (err_timeout),
    .cmd_count   (cmd_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Clean press: go must appear exactly after the 7th edge; btn left high
  task automatic launch(input string tag);
    btn_go = 1'b1;
    repeat (6) tick();
    check({tag, "_early"}, {31'd0, go}, 32'd1 - 32'd1);
    tick();
    check(tag, {31'd0, go}, 32'd1);
  endtask

  task automatic release_btn();
    btn_go = 1'b0;
    repeat (6) tick();
  endtask

  // Complete the running command with a done pulse and let the button settle
  task automatic finish_cmd(input string tag);
    btn_go = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_cnt++;
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    check({tag, "_cnt"}, {24'd0, cmd_count}, exp_cnt & 255);
    repeat (5) tick();
  endtask

  // Unchecked bulk command used to walk the counter
  task automatic run_cmd();
    int k;
    k = 0;
    btn_go = 1'b1;
    while (!go && k < 20) begin
      tick();
      k++;
    end
    if (!go) check("go_wait", 32'd0, 32'd1);
    btn_go = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_cnt++;
    repeat (5) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_outputs", {14'd0, go, busy, ack, err_overlap, err_timeout, op, in1, in2, cmd_count}, 32'd0);
    rst = 1'b0;
    tick();

    // 1. Basic command
    sw_op = OP_SUB; sw_in1 = 4'h9; sw_in2 = 4'h3;
    launch("t1_go");
    check("t1_op", {30'd0, op}, 32'd1);
    check("t1_in1", {28'd0, in1}, 32'h9);
    check("t1_in2", {28'd0, in2}, 32'h3);
    busy_cyc = int'(busy);
    tick();
    check("t1_go_width", {31'd0, go}, 32'd0);
    busy_cyc += int'(busy);
    repeat (5) begin
      tick();
      busy_cyc += int'(busy);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_cnt++;
    check("t1_busy_cycles", busy_cyc, 32'd7);
    check("t1_busy_low", {31'd0, busy}, 32'd0);
    check("t1_ack", {31'd0, ack}, 32'd1);
    check("t1_cnt", {24'd0, cmd_count}, 32'd1);
    tick();
    check("t1_ack_width", {31'd0, ack}, 32'd0);
    repeat (5) tick();
    release_btn();

    // 2. Bouncing button
    go_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn_go = (i % 2 == 0);
      repeat (2) begin
        tick();
        go_seen |= go;
      end
    end
    btn_go = 1'b1;
    repeat (6) begin
      tick();
      go_seen |= go;
    end
    check("t2_bounce_nogo", {31'd0, go_seen}, 32'd0);
    tick();
    check("t2_go", {31'd0, go}, 32'd1);
    finish_cmd("t2");

    // 3. Overlapping press while busy
    launch("t3_go1");
    btn_go = 1'b0;
    repeat (6) tick();
    btn_go = 1'b1;
    repeat (7) tick();
    check("t3_no_go2", {31'd0, go}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd1);
    check("t3_overlap", {31'd0, err_overlap}, 32'd1);
    finish_cmd("t3a");
    check("t3_overlap_sticky", {31'd0, err_overlap}, 32'd1);
    launch("t3_go3");
    check("t3_overlap_clr", {31'd0, err_overlap}, 32'd0);
    finish_cmd("t3b");

    // 4. Timeout, then done coinciding with the last allowed cycle
    launch("t4_go");
    btn_go = 1'b0;
    repeat (16) tick();
    check("t4_busy_last", {31'd0, busy}, 32'd1);
    check("t4_to_early", {31'd0, err_timeout}, 32'd0);
    tick();
    check("t4_busy_fall", {31'd0, busy}, 32'd0);
    check("t4_timeout", {31'd0, err_timeout}, 32'd1);
    check("t4_no_ack", {31'd0, ack}, 32'd0);
    check("t4_cnt", {24'd0, cmd_count}, exp_cnt);
    repeat (3) tick();
    launch("t4b_go");
    check("t4b_to_clr", {31'd0, err_timeout}, 32'd0);
    btn_go = 1'b0;
    repeat (16) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_cnt++;
    check("t4b_ack", {31'd0, ack}, 32'd1);
    check("t4b_no_to", {31'd0, err_timeout}, 32'd0);
    check("t4b_cnt", {24'd0, cmd_count}, exp_cnt);
    repeat (5) tick();

    // 5. Captured operands hold while switches move; done in IDLE ignored
    launch("t5_go");
    sw_in1 = 4'hF;
    sw_op  = OP_XOR;
    repeat (3) tick();
    check("t5_in1_busy", {28'd0, in1}, 32'h9);
    check("t5_op_busy", {30'd0, op}, 32'd1);
    finish_cmd("t5");
    check("t5_in1_idle", {28'd0, in1}, 32'h9);
    check("t5_op_idle", {30'd0, op}, 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t5_idle_done_ack", {31'd0, ack}, 32'd0);
    tick();
    check("t5_idle_done_ack2", {31'd0, ack}, 32'd0);
    check("t5_idle_done_cnt", {24'd0, cmd_count}, exp_cnt);

    // 6. Counter to 255, reset mid-busy, then 256 completions wrap to 0
    while (exp_cnt < 255) run_cmd();
    check("t6_cnt255", {24'd0, cmd_count}, 32'd255);
    launch("t6_go");
    btn_go = 1'b0;
    repeat (3) tick();
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_rst", {14'd0, go, busy, ack, err_overlap, err_timeout, op, in1, in2, cmd_count}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
    repeat (3) tick();
    repeat (256) run_cmd();
    check("t6_wrap", {24'd0, cmd_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
